// File: rtl/alu_src_b_stage_pkg.sv
// rtl/alu_src_b_stage_pkg.sv - operand-B select codes and skid-buffer occupancy states
package alu_src_b_stage_pkg;

  localparam logic [2:0] SRC_B        = 3'b000;
  localparam logic [2:0] SRC_INC      = 3'b001;
  localparam logic [2:0] SRC_SEXT     = 3'b010;
  localparam logic [2:0] SRC_SEXT_SL2 = 3'b011;
  localparam logic [2:0] SRC_ZEXT     = 3'b100;
  localparam logic [2:0] SRC_MDR      = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/alu_src_b_stage_imm_ext.sv
// rtl/alu_src_b_stage_imm_ext.sv - combinational sign/zero/shifted extension of a 16-bit immediate
module alu_src_b_stage_imm_ext #(
  parameter int WIDTH = 32
) (
  input  logic [15:0]      i_imm16,
  output logic [WIDTH-1:0] o_sext,
  output logic [WIDTH-1:0] o_sext_sl2,
  output logic [WIDTH-1:0] o_zext
);

  assign o_sext     = {{(WIDTH-16){i_imm16[15]}}, i_imm16};
  // Word-offset form: top two sign bits fall off so the result stays WIDTH bits
  assign o_sext_sl2 = {o_sext[WIDTH-3:0], 2'b00};
  assign o_zext     = {{(WIDTH-16){1'b0}}, i_imm16};

endmodule

// File: rtl/alu_src_b_stage.sv
// rtl/alu_src_b_stage.sv - registered ALU operand-B selector with a 2-entry skid buffer
module alu_src_b_stage
  import alu_src_b_stage_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int unsigned INC_CONST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       ALUSrcB,
  input  logic [WIDTH-1:0] in_b,
  input  logic [15:0]      in_imm16,
  input  logic [WIDTH-1:0] in_memoryDataReg,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sel_err
);

  localparam logic [WIDTH-1:0] W_INC = WIDTH'(INC_CONST);

  occ_state_t       r_state;
  occ_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_skid;
  logic             r_sel_err;

  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_sext_sl2;
  logic [WIDTH-1:0] w_zext;
  logic [WIDTH-1:0] w_operand;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  logic             w_load_head_in;
  logic             w_load_skid;
  logic             w_skid_to_head;

  alu_src_b_stage_imm_ext #(.WIDTH(WIDTH)) u_imm_ext (
    .i_imm16    (in_imm16),
    .o_sext     (w_sext),
    .o_sext_sl2 (w_sext_sl2),
    .o_zext     (w_zext)
  );

  always_comb begin
    w_operand = '0;
    w_illegal = 1'b0;
    case (ALUSrcB)
      SRC_B:        w_operand = in_b;
      SRC_INC:      w_operand = W_INC;
      SRC_SEXT:     w_operand = w_sext;
      SRC_SEXT_SL2: w_operand = w_sext_sl2;
      SRC_ZEXT:     w_operand = w_zext;
      SRC_MDR:      w_operand = in_memoryDataReg;
      default:      w_illegal = 1'b1;
    endcase
  end

  // Both handshake outputs derive only from registered state
  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign out       = r_head;
  assign sel_err   = r_sel_err;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_head_in = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_head = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = ST_FULL;
          w_load_skid = 1'b1;
        end else if (w_push && w_pop) begin
          w_load_head_in = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_head = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_head_in) begin
        r_head <= w_operand;
      end else if (w_skid_to_head) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_operand;
      end
    end
  end

  // A new illegal accept wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_err <= 1'b0;
    end else if (w_push && w_illegal) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// tb/tb_alu_src_b_stage.sv - directed and scoreboarded checks for alu_src_b_stage
module tb_alu_src_b_stage;

  logic        clk;
  logic        reset_n;
  logic [2:0]  ALUSrcB;
  logic [31:0] in_b;
  logic [15:0] in_imm16;
  logic [31:0] in_memoryDataReg;
  logic        in_valid;
  logic        in_ready;
  logic        err_clr;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  int n_pass;
  int n_total;

  alu_src_b_stage #(.WIDTH(32), .INC_CONST(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ALUSrcB          (ALUSrcB),
    .in_b             (in_b),
    .in_imm16         (in_imm16),
    .in_memoryDataReg (in_memoryDataReg),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .err_clr          (err_clr),
    .out              (out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .sel_err          (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [2:0] sel, input logic [31:0] b,
                                        input logic [15:0] imm, input logic [31:0] mdr);
    logic [31:0] s;
    s = 32'($signed(imm));
    case (sel)
      3'd0:    return b;
      3'd1:    return 32'd4;
      3'd2:    return s;
      3'd3:    return s * 4;
      3'd4:    return {16'h0000, imm};
      3'd5:    return mdr;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; ALUSrcB = 3'd0; in_b = '0; in_imm16 = '0; in_memoryDataReg = '0;
    in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b0;
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out !== 32'h0) $display("FAIL reset_out got %h want 0", out); else n_pass++;
    n_total++; if (sel_err !== 1'b0) $display("FAIL reset_sel_err got %b want 0", sel_err); else n_pass++;
    step();
    reset_n = 1'b1;
    step();
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_sext_pulse();
    ALUSrcB = 3'b010; in_imm16 = 16'h8000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_total++; if (out !== 32'hFFFF8000) $display("FAIL sext_out got %h want ffff8000", out); else n_pass++;
    n_total++; if (out_valid !== 1'b1) $display("FAIL sext_valid got %b want 1", out_valid); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL sext_single_pulse got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_decode();
    logic [2:0]  sel [5] = '{3'b011, 3'b100, 3'b001, 3'b000, 3'b101};
    logic [15:0] imm [5] = '{16'hFFFF, 16'h8001, 16'h1234, 16'h5555, 16'hAAAA};
    logic [31:0] exp [5] = '{32'hFFFFFFFC, 32'h00008001, 32'h00000004, 32'hDEADBEEF, 32'h12345678};
    in_b = 32'hDEADBEEF; in_memoryDataReg = 32'h12345678; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ALUSrcB = sel[i]; in_imm16 = imm[i]; in_valid = 1'b1;
      step();
      n_total++;
      if (out !== exp[i] || out_valid !== 1'b1)
        $display("FAIL decode_sel%0d got %h/%b want %h/1", sel[i], out, out_valid, exp[i]);
      else n_pass++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    ALUSrcB = 3'b000; out_ready = 1'b0; in_valid = 1'b1; in_b = 32'd1;
    step();
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_after1 got %b want 1", in_ready); else n_pass++;
    in_b = 32'd2;
    step();
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_ready_after2 got %b want 0", in_ready); else n_pass++;
    in_b = 32'd3;
    step();
    n_total++; if (out !== 32'd1 || out_valid !== 1'b1) $display("FAIL bp_hold got %h/%b want 1/1", out, out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_still_full got %b want 0", in_ready); else n_pass++;
    out_ready = 1'b1;
    step();
    n_total++; if (out !== 32'd2 || out_valid !== 1'b1) $display("FAIL bp_second got %h/%b want 2/1", out, out_valid); else n_pass++;
    step();
    in_valid = 1'b0;
    n_total++; if (out !== 32'd3 || out_valid !== 1'b1) $display("FAIL bp_third got %h/%b want 3/1", out, out_valid); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drained got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_sel_err();
    out_ready = 1'b1; ALUSrcB = 3'b111; in_valid = 1'b1; in_b = 32'hFFFFFFFF;
    step();
    in_valid = 1'b0;
    n_total++; if (out !== 32'h0 || out_valid !== 1'b1) $display("FAIL illegal_data got %h/%b want 0/1", out, out_valid); else n_pass++;
    n_total++; if (sel_err !== 1'b1) $display("FAIL illegal_set got %b want 1", sel_err); else n_pass++;
    step(); step();
    n_total++; if (sel_err !== 1'b1) $display("FAIL illegal_sticky got %b want 1", sel_err); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    n_total++; if (sel_err !== 1'b0) $display("FAIL err_clr got %b want 0", sel_err); else n_pass++;
    ALUSrcB = 3'b110; in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    n_total++; if (sel_err !== 1'b1) $display("FAIL set_over_clr got %b want 1", sel_err); else n_pass++;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    bit seen;
    ALUSrcB = 3'b000; out_ready = 1'b0; in_valid = 1'b1; in_b = 32'hAA;
    step();
    in_b = 32'hBB;
    step();
    in_valid = 1'b0;
    n_total++; if (in_ready !== 1'b0) $display("FAIL ar_full got %b want 0", in_ready); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || out !== 32'h0) $display("FAIL ar_immediate got %h/%b want 0/0", out, out_valid); else n_pass++;
    step();
    reset_n = 1'b1; out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_total++; if (seen) $display("FAIL ar_no_stale got 1 want 0"); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL ar_ready got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int bad_valid, bad_data, bad_ready;
    bad_valid = 0; bad_data = 0; bad_ready = 0;
    for (int c = 0; c < 3000; c++) begin
      if (out_valid !== (q.size() != 0)) bad_valid++;
      if (q.size() != 0 && out !== q[0]) bad_data++;
      if (in_ready !== (q.size() < 2)) bad_ready++;
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      ALUSrcB = 3'($urandom_range(0, 7));
      in_b = $urandom;
      in_imm16 = 16'($urandom);
      in_memoryDataReg = $urandom;
      err_clr = 1'b0;
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(model(ALUSrcB, in_b, in_imm16, in_memoryDataReg));
      step();
    end
    in_valid = 1'b0;
    n_total++; if (bad_valid != 0) $display("FAIL rand_out_valid got %0d errors want 0", bad_valid); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL rand_fifo_data got %0d errors want 0", bad_data); else n_pass++;
    n_total++; if (bad_ready != 0) $display("FAIL rand_in_ready got %0d errors want 0", bad_ready); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_sext_pulse();
    test_decode();
    test_back_to_back();
    test_sel_err();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
